// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM for the MM:SS lab stopwatch. It takes the 2 Hz enable from the
// clock divider and the debounced buttons, and steps the minute/second
// registers through the PAUSE, RUN and ADJUST modes.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   tick_2hz   in   one-cycle 2 Hz enable pulse
//   btn_pause  in   one-cycle pulse, toggles RUN/PAUSE
//   btn_reset  in   one-cycle pulse, clears the time
//   adj        in   level, 1 = adjust mode
//   sel        in   level, adjusted field: 0 = minutes, 1 = seconds
//   min_out    out  minutes, 0..MAX_VAL (registered)
//   sec_out    out  seconds, 0..MAX_VAL (registered)
//   running    out  1 while in RUN (registered)
//   blink      out  blink enable for the selected field in ADJUST (registered)
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned MAX_VAL = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_2hz,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       adj,
    input  logic       sel,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic       running,
    output logic       blink
);

    localparam logic [5:0] MAX_V = 6'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       half_q, half_d;
    logic       blink_q, blink_d;
    logic       running_q, running_d;
    logic       one_hz_s;

    // Increment with wrap to zero; anything at or above the terminal value
    // (including forced out-of-range values) goes back to 0.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v);
        logic [5:0] r;
        if (v >= MAX_V) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        sec_d    = sec_q;
        half_d   = half_q;
        blink_d  = blink_q;
        // The 1 Hz event is every second 2 Hz tick.
        one_hz_s = tick_2hz & half_q;

        if (btn_reset) begin
            // Clear wins over everything; a coincident tick is dropped.
            min_d  = 6'd0;
            sec_d  = 6'd0;
            half_d = 1'b0;
            if (adj) begin
                state_d = ST_ADJUST;
            end else begin
                state_d = ST_PAUSE;
                blink_d = 1'b0;
            end
        end else if (adj) begin
            case (state_q)
                ST_ADJUST: begin
                    if (tick_2hz) begin
                        // Selected field only, no carry between fields.
                        if (sel) begin
                            sec_d = wrap_inc(sec_q);
                        end else begin
                            min_d = wrap_inc(min_q);
                        end
                        blink_d = ~blink_q;
                    end else begin
                        blink_d = blink_q;
                    end
                end
                default: begin
                    // Entry from PAUSE or RUN restarts the tick phase.
                    state_d = ST_ADJUST;
                    half_d  = 1'b0;
                    blink_d = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                ST_PAUSE: begin
                    // Phase keeps running so a pause does not shift it.
                    if (tick_2hz) begin
                        half_d = ~half_q;
                    end else begin
                        half_d = half_q;
                    end
                    if (btn_pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_RUN: begin
                    if (tick_2hz) begin
                        half_d = ~half_q;
                    end else begin
                        half_d = half_q;
                    end
                    // Count is evaluated on the current state, so a
                    // coincident pause still lets this second land.
                    if (one_hz_s) begin
                        if (sec_q >= MAX_V) begin
                            sec_d = 6'd0;
                            min_d = wrap_inc(min_q);
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q;
                    end
                    if (btn_pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_ADJUST: begin
                    // Leaving adjust always parks in PAUSE.
                    state_d = ST_PAUSE;
                    blink_d = 1'b0;
                end
                default: begin
                    // Illegal encoding: recover to a safe paused state.
                    state_d = ST_PAUSE;
                    half_d  = 1'b0;
                    blink_d = 1'b0;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_PAUSE;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            half_q    <= 1'b0;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            half_q    <= half_d;
            blink_q   <= blink_d;
            running_q <= running_d;
        end
    end

    assign min_out = min_q;
    assign sec_out = sec_q;
    assign running = running_q;
    assign blink   = blink_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the lab stopwatch. Consumes the single-cycle 2 Hz enable pulse from the clock divider and debounced button pulses, and sequences the MM:SS time registers through run, pause and adjust modes. Sits between the divider and the seven-segment display driver. Drives the minute/second values and the blink enable for the selected field.

Parameters:
MAX_VAL, 59, terminal value for both the seconds and minutes fields (wraps MAX_VAL -> 0)

Ports:
clk  input  1  system clock (100 MHz); all logic on posedge clk
rst_n  input  1  asynchronous, active-low reset
tick_2hz  input  1  one-cycle enable pulse at 2 Hz from the divider
btn_pause  input  1  one-cycle pulse, already debounced; toggles run/pause
btn_reset  input  1  one-cycle pulse, already debounced; clears time
adj  input  1  level; 1 = adjust mode
sel  input  1  level; field to adjust: 0 = minutes, 1 = seconds
min_out  output  6  minutes, 0..MAX_VAL
sec_out  output  6  seconds, 0..MAX_VAL
running  output  1  1 while in RUN
blink  output  1  blink enable for the selected field in ADJUST; 0 otherwise

Behaviour:
- Async reset (rst_n=0): state=PAUSE, min_out=0, sec_out=0, half=0, running=0, blink=0. Reset is released synchronously to the next clk edge.
- States: PAUSE, RUN, ADJUST. All outputs are registered; any change appears on the clk edge after the triggering input cycle.
- half: 1-bit phase register, toggles on every tick_2hz outside ADJUST. The 1 Hz event is defined as tick_2hz && half==1.
- Priority within one cycle: btn_reset > adj > btn_pause.
- btn_reset, in any state:
  - min/sec/half cleared.
  - If adj=1, state stays ADJUST; otherwise state goes to PAUSE and running=0.
  - A simultaneous tick_2hz is discarded.
- State transitions:
  - adj=1 from PAUSE or RUN: state goes to ADJUST and half is cleared.
  - adj=0 while in ADJUST: state goes to PAUSE (never RUN directly).
  - btn_pause in PAUSE: state goes to RUN. btn_pause in RUN: state goes to PAUSE. btn_pause in ADJUST is ignored.
- RUN counting, on each 1 Hz event:
  - sec_out increments.
  - If sec_out==MAX_VAL: sec_out becomes 0 and min_out increments.
  - If min_out==MAX_VAL also: both fields become 0 (59:59 -> 00:00).
- Simultaneous btn_pause and 1 Hz event in RUN: the increment is applied, then state becomes PAUSE. The count is evaluated on the current state.
- PAUSE: min/sec hold. half still toggles on tick_2hz, so phase is preserved across a pause.
- ADJUST:
  - Normal counting is suspended.
  - On every tick_2hz, the field chosen by sel increments. It wraps MAX_VAL -> 0 with no carry into the other field.
  - blink toggles on every tick_2hz. blink is forced to 0 on exit from ADJUST.
  - A sel change takes effect on the next tick_2hz.
- Arithmetic: 6-bit unsigned. Values above MAX_VAL are unreachable; if forced, the next increment wraps the field to 0.
- Reset mid-operation, any state: the async clear has immediate effect and no pending event survives it.

Test Plan:
- Reset, then 4 tick_2hz with no buttons -> min=0, sec=0, running=0.
- btn_pause, then 6 tick_2hz -> running=1, sec=3. Then btn_pause and 4 more ticks -> sec stays 3, running=0.
- Preload 59:58 via adjust, RUN, 4 tick_2hz -> 59:59, then 00:00 (full wrap, no overflow).
- adj=1, sel=1, sec=58, 3 tick_2hz -> sec 59, 0, 1 with min unchanged; blink pattern 1,0,1. Drop adj -> state PAUSE, blink=0.
- In RUN, btn_pause asserted in the same cycle as a 1 Hz event (sec=10) -> sec=11, running=0. Then btn_reset with adj=1 -> 00:00, state remains ADJUST.
- Assert rst_n=0 asynchronously mid-RUN at 12:34 -> outputs 00:00, running=0 before the next clk edge; after release, 2 ticks do not count.
